// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load-data extraction, register-file
// write port drive and a retired-instruction counter.
module wb_stage #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic                 M_Valid,
  input  logic                 M_RegWrite,
  input  logic [1:0]           M_WbSel,
  input  logic [2:0]           M_LoadType,
  input  logic [4:0]           M_RdAddr,
  input  logic [31:0]          M_AluResult,
  input  logic [31:0]          M_MemData,
  input  logic [31:0]          M_PcPlus8,
  output logic [4:0]           RdAddr,
  output logic [31:0]          RdData,
  output logic                 RegWrite,
  output logic                 W_Valid,
  output logic [CNT_WIDTH-1:0] RetireCount
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic                 valid_r;
  logic                 regwrite_r;
  logic [1:0]           wbsel_r;
  logic [2:0]           loadtype_r;
  logic [4:0]           rdaddr_r;
  logic [31:0]          alu_r;
  logic [31:0]          mem_r;
  logic [31:0]          pc8_r;
  logic [CNT_WIDTH-1:0] retire_r;
  logic                 capture_s;
  logic [31:0]          load_s;
  logic [31:0]          rddata_s;

  // Little-endian sub-word extraction; unknown load codes fall back to a full word.
  function automatic logic [31:0] extract_load(
    input logic [2:0]  ltype,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (off[1] == 1'b1) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (ltype)
      LD_LW:   res_v = word;
      LD_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  res_v = {24'h00_0000, byte_v};
      LD_LH:   res_v = {{16{half_v[15]}}, half_v};
      LD_LHU:  res_v = {16'h0000, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  assign capture_s = (Flush == 1'b0) && (Stall == 1'b0);

  // MEM/WB register: flush inserts a bubble (and wins over stall), stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
      wbsel_r    <= 2'b00;
      loadtype_r <= 3'b000;
      rdaddr_r   <= 5'd0;
      alu_r      <= 32'h0000_0000;
      mem_r      <= 32'h0000_0000;
      pc8_r      <= 32'h0000_0000;
    end else if (Flush) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
    end else if (!Stall) begin
      valid_r    <= M_Valid;
      regwrite_r <= M_RegWrite;
      wbsel_r    <= M_WbSel;
      loadtype_r <= M_LoadType;
      rdaddr_r   <= M_RdAddr;
      alu_r      <= M_AluResult;
      mem_r      <= M_MemData;
      pc8_r      <= M_PcPlus8;
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_r <= '0;
    end else if (capture_s && M_Valid) begin
      retire_r <= retire_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign load_s = extract_load(loadtype_r, alu_r[1:0], mem_r);

  // Write-data source select; code 11 behaves as the ALU path.
  always_comb begin
    rddata_s = alu_r;
    case (wbsel_r)
      SEL_ALU:  rddata_s = alu_r;
      SEL_LOAD: rddata_s = load_s;
      SEL_LINK: rddata_s = pc8_r;
      default:  rddata_s = alu_r;
    endcase
  end

  assign RdAddr      = rdaddr_r;
  assign RdData      = rddata_s;
  assign RegWrite    = valid_r && regwrite_r && (rdaddr_r != 5'd0);
  assign W_Valid     = valid_r;
  assign RetireCount = retire_r;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed checks of wb_stage against a behavioural write-back model.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        Stall, Flush, M_Valid, M_RegWrite;
  logic [1:0]  M_WbSel;
  logic [2:0]  M_LoadType;
  logic [4:0]  M_RdAddr;
  logic [31:0] M_AluResult, M_MemData, M_PcPlus8;
  logic [4:0]  RdAddr, RdAddr4;
  logic [31:0] RdData, RdData4;
  logic        RegWrite, RegWrite4, W_Valid, W_Valid4;
  logic [31:0] RetireCount;
  logic [3:0]  RetireCount4;

  int checks = 0;
  int errors = 0;

  // Model of the latched WB entry and the expected counters.
  logic        e_valid, e_rw;
  logic [1:0]  e_sel;
  logic [2:0]  e_lt;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_mem, e_pc;
  longint      n_retired;

  wb_stage #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .M_Valid(M_Valid),
    .M_RegWrite(M_RegWrite), .M_WbSel(M_WbSel), .M_LoadType(M_LoadType),
    .M_RdAddr(M_RdAddr), .M_AluResult(M_AluResult), .M_MemData(M_MemData),
    .M_PcPlus8(M_PcPlus8), .RdAddr(RdAddr), .RdData(RdData), .RegWrite(RegWrite),
    .W_Valid(W_Valid), .RetireCount(RetireCount)
  );

  wb_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .M_Valid(M_Valid),
    .M_RegWrite(M_RegWrite), .M_WbSel(M_WbSel), .M_LoadType(M_LoadType),
    .M_RdAddr(M_RdAddr), .M_AluResult(M_AluResult), .M_MemData(M_MemData),
    .M_PcPlus8(M_PcPlus8), .RdAddr(RdAddr4), .RdData(RdData4), .RegWrite(RegWrite4),
    .W_Valid(W_Valid4), .RetireCount(RetireCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    logic [31:0] v;
    int off;
    off = int'(e_alu[1:0]);
    if (e_sel == 2'd2) return e_pc;
    if (e_sel != 2'd1) return e_alu;
    case (e_lt)
      3'd1, 3'd2: begin
        v = (e_mem >> (8 * off)) & 32'h0000_00FF;
        if (e_lt == 3'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        v = ((off >= 2) ? (e_mem >> 16) : e_mem) & 32'h0000_FFFF;
        if (e_lt == 3'd3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = e_mem;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    e_valid = 1'b0; e_rw = 1'b0; e_sel = 2'd0; e_lt = 3'd0; e_rd = 5'd0;
    e_alu = 32'd0; e_mem = 32'd0; e_pc = 32'd0; n_retired = 0;
  endtask

  task automatic compare_all();
    check("w_valid", {31'd0, W_Valid}, {31'd0, e_valid});
    check("regwrite", {31'd0, RegWrite}, {31'd0, e_valid && e_rw && (e_rd != 5'd0)});
    check("retire32", RetireCount, 32'(n_retired));
    check("retire4", {28'd0, RetireCount4}, 32'(n_retired % 16));
    if (e_valid) begin
      check("rdaddr", {27'd0, RdAddr}, {27'd0, e_rd});
      check("rddata", RdData, exp_data());
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc,
                       input logic st, input logic fl);
    M_Valid = v; M_RegWrite = rw; M_WbSel = sel; M_LoadType = lt; M_RdAddr = rd;
    M_AluResult = alu; M_MemData = mem; M_PcPlus8 = pc; Stall = st; Flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    if (Flush) begin
      e_valid = 1'b0; e_rw = 1'b0;
    end else if (!Stall) begin
      e_valid = M_Valid; e_rw = M_RegWrite; e_sel = M_WbSel; e_lt = M_LoadType;
      e_rd = M_RdAddr; e_alu = M_AluResult; e_mem = M_MemData; e_pc = M_PcPlus8;
      if (M_Valid) n_retired++;
    end
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    model_reset();
    #2;
    check("rst_rddata", RdData, 32'd0);
    check("rst_rdaddr", {27'd0, RdAddr}, 32'd0);
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_count", RetireCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU path
    drive(1'b1, 1'b1, 2'b00, 3'd0, 5'd8, 32'h0000_1234, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    step();
    check("alu_rddata", RdData, 32'h0000_1234);
    check("alu_rdaddr", {27'd0, RdAddr}, 32'd8);
    check("alu_regwrite", {31'd0, RegWrite}, 32'd1);
    check("alu_count", RetireCount, 32'd1);

    // Load extraction at byte offset 2
    for (int i = 0; i < 5; i++) begin
      logic [31:0] want [5];
      want[0] = 32'h80FF_7F01; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0000_00FF;
      want[3] = 32'hFFFF_80FF; want[4] = 32'h0000_80FF;
      drive(1'b1, 1'b1, 2'b01, 3'(i), 5'd5, 32'h0000_0002, 32'h80FF_7F01, 32'd0, 1'b0, 1'b0);
      step();
      check($sformatf("load_lt%0d", i), RdData, want[i]);
    end

    // R0 guard, then link
    drive(1'b1, 1'b1, 2'b00, 3'd0, 5'd0, 32'h1111_2222, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check("r0_regwrite", {31'd0, RegWrite}, 32'd0);
    drive(1'b1, 1'b1, 2'b10, 3'd0, 5'd31, 32'h0000_0004, 32'd0, 32'h0040_0010, 1'b0, 1'b0);
    step();
    check("link_rddata", RdData, 32'h0040_0010);
    check("link_regwrite", {31'd0, RegWrite}, 32'd1);

    // Stall two cycles with different inputs, then stall+flush
    held = RetireCount;
    drive(1'b1, 1'b1, 2'b00, 3'd0, 5'd9, 32'hAAAA_5555, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    step();
    check("stall_rddata", RdData, 32'h0040_0010);
    check("stall_count", RetireCount, held);
    drive(1'b1, 1'b1, 2'b00, 3'd0, 5'd9, 32'hAAAA_5555, 32'd0, 32'd0, 1'b1, 1'b1);
    step();
    check("sf_wvalid", {31'd0, W_Valid}, 32'd0);
    check("sf_count", RetireCount, held);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
      step();
    end

    // Mid-cycle reset with a valid write pending
    drive(1'b1, 1'b1, 2'b00, 3'd0, 5'd12, 32'h0BAD_F00D, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("mrst_rddata", RdData, 32'd0);
    check("mrst_count", RetireCount, 32'd0);
    check("mrst_wvalid", {31'd0, W_Valid}, 32'd0);
    @(negedge clk);
    check("mrst_negedge_regwrite", {31'd0, RegWrite}, 32'd0);
    rst_n = 1'b1;

    // Wrap of the 4-bit counter: 17 captures
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'd0, 5'(i + 1), 32'(i), 32'd0, 32'd0, 1'b0, 1'b0);
      step();
    end
    check("wrap4", {28'd0, RetireCount4}, 32'd1);
    check("wrap32", RetireCount, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Stall  input  1  hold MEM/WB contents this cycle.
REQ-005 Flush  input  1  load a bubble into MEM/WB this cycle.
REQ-006 M_Valid  input  1  MEM-stage instruction valid.
REQ-007 M_RegWrite  input  1  MEM-stage instruction writes a register.
REQ-008 M_WbSel  input  2  source select: 00 ALU, 01 load, 10 link, 11 treated as ALU.
REQ-009 M_LoadType  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; other codes treated as lw.
REQ-010 M_RdAddr  input  5  destination register.
REQ-011 M_AluResult  input  32  ALU result / effective address.
REQ-012 M_MemData  input  32  aligned word read from data memory.
REQ-013 M_PcPlus8  input  32  link value.
REQ-014 RdAddr  output  5  register-file write address.
REQ-015 RdData  output  32  register-file write data.
REQ-016 RegWrite  output  1  register-file write enable.
REQ-017 W_Valid  output  1  WB-stage entry valid (for forwarding/hazard logic).
REQ-018 RetireCount  output  CNT_WIDTH  count of instructions captured into WB.

Function
REQ-019 MEM/WB register SHALL hold valid, RegWrite, WbSel, LoadType, RdAddr, AluResult, MemData, PcPlus8.
REQ-020 Each posedge: Flush=1 -> valid and RegWrite cleared, other fields don't-care; else Stall=1 -> all fields hold; else all fields load from M_* inputs.
REQ-021 Flush SHALL take priority over Stall when both are 1.
REQ-022 Latency: instruction presented on M_* at posedge N drives RdAddr/RdData/RegWrite from just after posedge N until the next update; the register file commits it at the following negedge (same cycle).
REQ-023 RdData SHALL be combinational from the MEM/WB register: WbSel 00/11 -> AluResult; 01 -> extracted load data; 10 -> PcPlus8.
REQ-024 Load extraction, little-endian, off = AluResult[1:0]: lw -> MemData; lb/lbu -> byte MemData[8*off+7:8*off], sign-/zero-extended to 32.
REQ-025 lh/lhu -> half MemData[15:0] if AluResult[1]=0 else MemData[31:16], sign-/zero-extended; AluResult[0] ignored (no misalignment trap).
REQ-026 RegWrite = W_Valid AND latched RegWrite AND (RdAddr != 0); writes to R0 SHALL never be asserted.
REQ-027 RdAddr SHALL present the latched address even when RegWrite is 0.
REQ-028 RetireCount SHALL increment by 1 on each posedge where Flush=0, Stall=0, M_Valid=1; wraps from all-ones to 0 with no flag.
REQ-029 RetireCount SHALL not change on stalled or flushed cycles.
REQ-030 While Stall=1 the same write SHALL be re-presented each cycle; rewriting identical data is permitted.

Reset
REQ-031 rst_n=0 SHALL immediately (no clock needed) clear all MEM/WB fields and RetireCount to 0, giving RdAddr=0, RdData=0, RegWrite=0, W_Valid=0.
REQ-032 Reset asserted mid-operation SHALL discard the in-flight WB entry; no write SHALL occur on the next negedge.
REQ-033 First capture SHALL occur on the first posedge with rst_n=1.

Verification
REQ-034 Reset: rst_n=0 mid-cycle with valid WB entry -> RegWrite=0, RdData=0, RetireCount=0 before next edge.
REQ-035 ALU path: M_Valid=1, RegWrite=1, WbSel=00, RdAddr=8, AluResult=0x0000_1234 -> after posedge RegWrite=1, RdAddr=8, RdData=0x0000_1234, RetireCount=1.
REQ-036 Loads: MemData=0x80FF_7F01, AluResult=...02; lb -> 0xFFFF_FFFF? no: byte2=0xFF -> 0xFFFF_FFFF; lbu -> 0x0000_00FF; lh -> 0xFFFF_80FF; lhu -> 0x0000_80FF; lw -> 0x80FF_7F01.
REQ-037 R0 guard and link: RdAddr=0, RegWrite=1 -> RegWrite=0; WbSel=10, RdAddr=31, PcPlus8=0x0040_0010 -> RdData=0x0040_0010, RegWrite=1.
REQ-038 Stall/Flush: Stall=1 two cycles -> outputs and RetireCount frozen; Stall=1 and Flush=1 together -> W_Valid=0, RegWrite=0, count unchanged.
REQ-039 Wrap: CNT_WIDTH=4, 17 valid captures -> RetireCount=1.
